// File: rtl/keypad_pkg.sv
// Shared types, key codes and frame classification for the keypad front-end.
package keypad_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONFIRM, S_HELD, S_RELEASE} state_t;
  typedef enum logic [1:0] {F_NONE, F_SINGLE, F_MULTI} fclass_t;

  typedef struct packed {
    fclass_t    cls;
    logic [3:0] code;
  } frame_info_t;

  localparam logic [3:0] KEY_STAR  = 4'd10;
  localparam logic [3:0] KEY_SHARP = 4'd11;

  // Frame bit (row*3+col) to key code. Rows: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  localparam logic [11:0][3:0] KEY_MAP = {KEY_SHARP, 4'd0, KEY_STAR,
                                          4'd9, 4'd8, 4'd7,
                                          4'd6, 4'd5, 4'd4,
                                          4'd3, 4'd2, 4'd1};

  // Count pressed bits; report the key code only when exactly one is set.
  function automatic frame_info_t classify(input logic [11:0] frame);
    frame_info_t info;
    int unsigned n;
    info.cls  = F_NONE;
    info.code = 4'd0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (frame[i]) begin
        n++;
        info.code = KEY_MAP[i];
      end
    end
    if (n == 1)     info.cls = F_SINGLE;
    else if (n > 1) info.cls = F_MULTI;
    return info;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Row scanner: dwell timer, registered row drive, column synchronizer and
// assembly of the 12-bit pressed vector for one full scan.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  col_n,
  output logic [3:0]  row_n,
  output logic [11:0] frame,
  output logic        frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] dwell;
  logic [1:0]    row;
  logic [2:0]    col_meta, col_sync;
  logic [8:0]    rows_buf;
  logic          last;

  assign last       = (dwell == LAST);
  assign frame_done = last && (row == 2'd3);
  // Row 3 is taken straight from the synchronizer on the frame_done cycle.
  assign frame      = {~col_sync, rows_buf};

  // Two-flop synchronizer; released columns read high through the pull-ups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  // Dwell counter; on its last cycle step to the next row and drive it low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
      row   <= 2'd0;
      row_n <= 4'b1110;
    end else if (last) begin
      dwell <= '0;
      row   <= row + 2'd1;
      row_n <= ~(4'b0001 << (row + 2'd1));
    end else begin
      dwell <= dwell + CW'(1);
    end
  end

  // Hold rows 0..2 until the row-3 sample completes the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rows_buf <= '0;
    else if (last && row != 2'd3) rows_buf[row*3 +: 3] <= ~col_sync;
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// Keypad front-end: frame debounce FSM and registered key outputs.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] d,
  output logic       sharp,
  output logic       star,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_press
);

  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CW-1:0] DF  = CW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [11:0]   frame;
  logic          frame_done;
  frame_info_t   info;
  state_t        state, state_d;
  logic [3:0]    cand, cand_d;
  logic [CW-1:0] cnt, cnt_d, cnt_inc;
  logic          acc, rel, same;
  logic [9:0]    d_d;
  logic          sharp_d, star_d, valid_d, press_d;
  logic [3:0]    code_d;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .col_n      (col_n),
    .row_n      (row_n),
    .frame      (frame),
    .frame_done (frame_done)
  );

  assign info    = classify(frame);
  assign same    = (info.cls == F_SINGLE) && (info.code == cand);
  assign cnt_inc = (cnt == DF) ? cnt : cnt + ONE;

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cand      <= 4'd0;
      cnt       <= '0;
      d         <= '0;
      sharp     <= 1'b0;
      star      <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      key_press <= 1'b0;
    end else begin
      state     <= state_d;
      cand      <= cand_d;
      cnt       <= cnt_d;
      d         <= d_d;
      sharp     <= sharp_d;
      star      <= star_d;
      key_valid <= valid_d;
      key_code  <= code_d;
      key_press <= press_d;
    end
  end

  // Next state: only a completed frame moves the debouncer.
  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    acc     = 1'b0;
    rel     = 1'b0;
    if (frame_done) begin
      case (state)
        S_IDLE: begin
          if (info.cls == F_SINGLE) begin
            cand_d = info.code;
            cnt_d  = ONE;
            if (ONE == DF) begin
              acc     = 1'b1;
              state_d = S_HELD;
            end else begin
              state_d = S_CONFIRM;
            end
          end
        end
        S_CONFIRM: begin
          if (same) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF) begin
              acc     = 1'b1;
              state_d = S_HELD;
            end
          end else if (info.cls == F_SINGLE) begin
            cand_d = info.code;
            cnt_d  = ONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HELD: begin
          if (!same) begin
            cnt_d = ONE;
            if (ONE == DF) begin
              rel     = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (same) begin
            state_d = S_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DF) begin
              rel     = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output values: set one-hot on accept, clear on release, otherwise hold.
  always_comb begin
    d_d     = d;
    sharp_d = sharp;
    star_d  = star;
    valid_d = key_valid;
    code_d  = key_code;
    press_d = 1'b0;
    if (acc) begin
      d_d     = (cand_d <= 4'd9) ? (10'd1 << cand_d) : 10'd0;
      sharp_d = (cand_d == KEY_SHARP);
      star_d  = (cand_d == KEY_STAR);
      valid_d = 1'b1;
      code_d  = cand_d;
      press_d = 1'b1;
    end else if (rel) begin
      d_d     = '0;
      sharp_d = 1'b0;
      star_d  = 1'b0;
      valid_d = 1'b0;
      code_d  = 4'd0;
    end
  end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Frame-accurate bench: a keypad matrix model driven one full frame at a time
// and a run-length debounce model derived from the accept/release rules.
module tb_keypad_scan_debounce;

  localparam int SD   = 4;
  localparam int DF   = 3;
  localparam int FCLK = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] d;
  logic       sharp, star, key_valid, key_press;
  logic [3:0] key_code;

  logic [11:0] keys = '0;   // pressed keys by matrix position row*3+col
  logic [11:0] stim[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  int held, streak, streak_key;
  bit exp_press;

  always #5 clk = ~clk;

  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .d         (d),
    .sharp     (sharp),
    .star      (star),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_press (key_press)
  );

  // A pressed key shorts its row to its column.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Layout: 1 2 3 / 4 5 6 / 7 8 9 / * 0 #
  function automatic int key_pos(input int k);
    case (k)
      0:       return 10;
      10:      return 9;
      11:      return 11;
      default: return k - 1;
    endcase
  endfunction

  function automatic int pos_key(input int p);
    case (p)
      9:       return 10;
      10:      return 0;
      11:      return 11;
      default: return p + 1;
    endcase
  endfunction

  function automatic logic [11:0] kbit(input int k);
    logic [11:0] v;
    v = '0;
    v[key_pos(k)] = 1'b1;
    return v;
  endfunction

  // Key code of a frame with exactly one key down, else -1.
  function automatic int frame_code(input logic [11:0] k);
    if ($countones(k) != 1) return -1;
    for (int p = 0; p < 12; p++) if (k[p]) return pos_key(p);
    return -1;
  endfunction

  task automatic model_reset();
    held = -1; streak = 0; streak_key = -1; exp_press = 0;
  endtask

  // Idle: accept after DF consecutive frames showing the same single key.
  // Held: release after DF consecutive frames not showing the held key alone.
  task automatic model_step(input int c);
    exp_press = 0;
    if (held < 0) begin
      if (c < 0) streak = 0;
      else if (streak > 0 && c == streak_key) streak++;
      else begin streak_key = c; streak = 1; end
      if (streak >= DF) begin held = c; streak = 0; exp_press = 1; end
    end else begin
      if (c == held) streak = 0;
      else streak++;
      if (streak >= DF) begin held = -1; streak = 0; end
    end
  endtask

  task automatic check_outputs(input string tag, input bit press);
    logic [9:0] ed;
    ed = (held >= 0 && held <= 9) ? (10'd1 << held) : 10'd0;
    chk({tag, "_d"},     d,         ed);
    chk({tag, "_sharp"}, sharp,     held == 11);
    chk({tag, "_star"},  star,      held == 10);
    chk({tag, "_valid"}, key_valid, held >= 0);
    chk({tag, "_code"},  key_code,  (held >= 0) ? held : 0);
    chk({tag, "_press"}, key_press, press);
  endtask

  // Entered just after a frame edge (row 0 starting); leaves one frame later.
  task automatic run_frame(input logic [11:0] k);
    keys = k;
    @(negedge clk);
    chk("press_width", key_press, 1'b0);
    chk("row0", row_n, 4'b1110);
    repeat (FCLK - 2) @(negedge clk);
    chk("row3", row_n, 4'b0111);
    check_outputs("pre", 1'b0);
    @(negedge clk);
    model_step(frame_code(k));
    check_outputs("post", exp_press);
  endtask

  task automatic add(input logic [11:0] k, input int n);
    for (int i = 0; i < n; i++) stim.push_back(k);
  endtask

  initial begin
    model_reset();
    // quiet keypad, clean '5', bouncy '#', two-key rejection, '7' -> '8'
    add(12'd0, 100);
    add(kbit(5), 4);  add(12'd0, 4);
    add(kbit(11), 1); add(12'd0, 1); add(kbit(11), 5);
    add(12'd0, 1);    add(kbit(11), 2); add(12'd0, 4);
    add(kbit(1) | kbit(2), 10); add(kbit(1), 4); add(12'd0, 4);
    add(kbit(7), 4);  add(kbit(8), 7); add(12'd0, 4);
    for (int s = 0; s < 60; s++) begin
      int kind, a, b;
      logic [11:0] v;
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 11);
      b = (a + $urandom_range(1, 11)) % 12;
      v = '0;
      if (kind == 1 || kind == 2) v[a] = 1'b1;
      else if (kind == 3) begin v[a] = 1'b1; v[b] = 1'b1; end
      add(v, $urandom_range(1, 5));
    end

    repeat (2) @(negedge clk);
    check_outputs("reset", 1'b0);
    chk("reset_row", row_n, 4'b1110);
    rst = 1'b0;
    foreach (stim[i]) run_frame(stim[i]);

    // async reset mid-frame with '0' held
    for (int i = 0; i < 4; i++) run_frame(kbit(0));
    chk("held0", d, 10'd1);
    repeat (7) @(negedge clk);
    chk("mid_row", row_n, 4'b1101);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("arst", 1'b0);
    chk("arst_row", row_n, 4'b1110);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) run_frame(kbit(0));
    chk("reheld0", d, 10'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
